// File: rtl/pll_reset_seq_if.sv
// pll_reset_seq_if: lock input, flag clear and reset/tick outputs of the PLL reset sequencer
interface pll_reset_seq_if;
    logic       PLL_LOCK;
    logic       CLR_FLAG;
    logic       SYS_RESET;
    logic       READY;
    logic       TICK_US;
    logic       TICK_MS;
    logic       LOCK_LOST;
    logic [7:0] LOSS_COUNT;
    modport master (
        output PLL_LOCK, CLR_FLAG,
        input  SYS_RESET, READY, TICK_US, TICK_MS, LOCK_LOST, LOSS_COUNT
    );
    modport slave (
        input  PLL_LOCK, CLR_FLAG,
        output SYS_RESET, READY, TICK_US, TICK_MS, LOCK_LOST, LOSS_COUNT
    );
endinterface

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: qualifies PLL lock, sequences system reset release, makes 1 us / 1 ms ticks, logs lock loss
module pll_reset_seq #(
    parameter int CLK_HZ             = 50_000_000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES        = 16,
    parameter int SYNC_STAGES        = 2
) (
    input logic            CLK,
    input logic            RESET,
    pll_reset_seq_if.slave bus
);
    localparam int US_DIV  = CLK_HZ / 1_000_000;
    localparam int US_W    = $clog2(US_DIV);
    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    generate
        if (CLK_HZ % 1_000_000 != 0 || CLK_HZ < 2_000_000 || LOCK_STABLE_CYCLES < 1 ||
            HOLD_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_param
            $error("pll_reset_seq: CLK_HZ must be a multiple of 1 MHz and >= 2 MHz; cycle counts >= 1; SYNC_STAGES >= 2");
        end
    endgenerate
    typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [US_W-1:0]        us_q, us_d;
    logic [9:0]             ms_q, ms_d;
    logic                   lost_q, lost_d;
    logic [7:0]             loss_q, loss_d;
    logic                   lock_s, stay_run, run_loss, tick_us, tick_ms;
    assign lock_s = sync_q[SYNC_STAGES-1];
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= WAIT_LOCK;
            sync_q  <= '0;
            cnt_q   <= '0;
            us_q    <= '0;
            ms_q    <= '0;
            lost_q  <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            us_q    <= us_d;
            ms_q    <= ms_d;
            lost_q  <= lost_d;
            loss_q  <= loss_d;
        end
    end
    // Any drop of the synced lock restarts qualification from WAIT_LOCK
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            WAIT_LOCK: state_d = lock_s ? STABLE : WAIT_LOCK;
            STABLE:
                if (!lock_s) state_d = WAIT_LOCK;
                else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) state_d = HOLD;
                else cnt_d = cnt_q + CNT_W'(1);
            HOLD:
                if (!lock_s) state_d = WAIT_LOCK;
                else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = RUN;
                else cnt_d = cnt_q + CNT_W'(1);
            RUN:       state_d = lock_s ? RUN : WAIT_LOCK;
        endcase
    end
    // Tick counters only advance while RUN persists, so they read 0 in every non-RUN cycle
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], bus.PLL_LOCK};
        stay_run = state_q == RUN && lock_s;
        run_loss = state_q == RUN && !lock_s;
        tick_us  = state_q == RUN && us_q == US_W'(US_DIV - 1);
        tick_ms  = tick_us && ms_q == 10'd999;
        us_d     = (stay_run && !tick_us) ? us_q + US_W'(1) : '0;
        ms_d     = !stay_run ? '0 : tick_ms ? '0 : tick_us ? ms_q + 10'd1 : ms_q;
        lost_d   = run_loss | (lost_q & ~bus.CLR_FLAG);
        loss_d   = (run_loss && loss_q != 8'hFF) ? loss_q + 8'd1 : loss_q;
    end
    always_comb begin
        bus.SYS_RESET  = state_q != RUN;
        bus.READY      = state_q == RUN;
        bus.TICK_US    = tick_us;
        bus.TICK_MS    = tick_ms;
        bus.LOCK_LOST  = lost_q;
        bus.LOSS_COUNT = loss_q;
    end
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: small-parameter and default instances checked every cycle against a run-length model
module tb_pll_reset_seq;
    localparam int SA = 2, LA = 8, HA = 4, HZA = 4_000_000;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    bit in_rst [2];
    bit in_lock[2];
    bit in_clr [2];
    logic rst_a, rst_b;
    pll_reset_seq_if ia ();
    pll_reset_seq_if ib ();
    assign rst_a       = in_rst[0];
    assign rst_b       = in_rst[1];
    assign ia.PLL_LOCK = in_lock[0];
    assign ia.CLR_FLAG = in_clr[0];
    assign ib.PLL_LOCK = in_lock[1];
    assign ib.CLR_FLAG = in_clr[1];
    pll_reset_seq #(.CLK_HZ(HZA), .LOCK_STABLE_CYCLES(LA), .HOLD_CYCLES(HA), .SYNC_STAGES(SA))
        dut_a (.CLK(clk), .RESET(rst_a), .bus(ia.slave));
    pll_reset_seq dut_b (.CLK(clk), .RESET(rst_b), .bus(ib.slave));
    logic [12:0] obs [2];
    assign obs[0] = {ia.SYS_RESET, ia.READY, ia.TICK_US, ia.TICK_MS, ia.LOCK_LOST, ia.LOSS_COUNT};
    assign obs[1] = {ib.SYS_RESET, ib.READY, ib.TICK_US, ib.TICK_MS, ib.LOCK_LOST, ib.LOSS_COUNT};
    int ps  [2] = '{SA, 2};
    int pl  [2] = '{LA, 1024};
    int ph  [2] = '{HA, 16};
    int pdiv[2] = '{HZA / 1_000_000, 50};
    bit     dl[2][8];
    longint r[2];
    bit     m_run[2];
    bit     m_lost[2];
    int     m_cnt[2];
    int     n_loss[2];
    int     n_tests = 0, n_fail = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Released once the synced lock has been high for L+H+1 consecutive edges
    task automatic step_model(input int i);
        bit ls, was;
        if (in_rst[i]) begin
            for (int k = 0; k < 8; k++) dl[i][k] = 1'b0;
            r[i] = 0; m_run[i] = 0; m_lost[i] = 0; m_cnt[i] = 0;
        end else begin
            ls = dl[i][ps[i]-1];
            was = m_run[i];
            r[i] = ls ? r[i] + 1 : 0;
            m_run[i] = r[i] >= pl[i] + ph[i] + 1;
            if (was && !ls) begin
                m_lost[i] = 1;
                n_loss[i]++;
                if (m_cnt[i] < 255) m_cnt[i]++;
            end else if (in_clr[i]) m_lost[i] = 0;
            for (int k = 7; k > 0; k--) dl[i][k] = dl[i][k-1];
            dl[i][0] = in_lock[i];
        end
    endtask
    function automatic logic [12:0] expect_vec(input int i);
        longint k = r[i] - (pl[i] + ph[i]);
        bit tu = m_run[i] && (k % pdiv[i] == 0);
        bit tm = m_run[i] && (k % (pdiv[i] * 1000) == 0);
        return {!m_run[i], m_run[i], tu, tm, m_lost[i], 8'(m_cnt[i])};
    endfunction
    task automatic tick();
        @(posedge clk);
        step_model(0);
        step_model(1);
        @(negedge clk);
        check("cycle_a", 32'(obs[0]), 32'(expect_vec(0)));
        check("cycle_b", 32'(obs[1]), 32'(expect_vec(1)));
    endtask
    task automatic latency(input int i, input string tag, input int want);
        int e = 0;
        while (e < 2000) begin
            tick();
            if (obs[i][11]) break;
            e++;
        end
        check(tag, e, want);
    endtask
    int c, first_us, n_us, e, iter;
    initial begin
        in_rst  = '{1, 1};
        in_lock = '{0, 0};
        in_clr  = '{0, 0};
        repeat (3) tick();
        check("reset_a", 32'(obs[0]), 32'h1000);
        check("reset_b", 32'(obs[1]), 32'h1000);
        in_rst[1] = 0; in_lock[1] = 1;
        latency(1, "t2_release", 1042);
        c = 1; first_us = 0; n_us = 0;
        while (c < 60000 && !obs[1][9]) begin
            tick();
            c++;
            if (obs[1][10]) begin
                n_us++;
                if (first_us == 0) first_us = c;
            end
        end
        check("t2_first_us", first_us, 50);
        check("t2_first_ms", c, 50000);
        check("t2_ms_with_us", 32'(obs[1][10]), 1);
        check("t2_us_count", n_us, 1000);
        in_rst[1] = 1;
        tick();
        in_rst[0] = 0; in_lock[0] = 1;
        latency(0, "t1_release", 14);
        in_rst[0] = 1; in_lock[0] = 0;
        repeat (3) tick();
        in_rst[0] = 0; in_lock[0] = 1;
        repeat (6) tick();
        in_lock[0] = 0;
        repeat (5) tick();
        check("t4_ready", 32'(obs[0][11]), 0);
        check("t4_lost", 32'(obs[0][8]), 0);
        check("t4_cnt", 32'(obs[0][7:0]), 0);
        in_lock[0] = 1;
        latency(0, "t4_requal", 14);
        repeat (3) tick();
        in_lock[0] = 0;
        e = 1;
        while (e < 20) begin
            tick();
            if (!obs[0][11]) break;
            e++;
        end
        check("t3_drop_edge", e, 3);
        check("t3_lost", 32'(obs[0][8]), 1);
        check("t3_cnt", 32'(obs[0][7:0]), 1);
        check("t3_ticks", 32'(obs[0][10:9]), 0);
        repeat (7) tick();
        in_lock[0] = 1;
        latency(0, "t3_rerelease", 14);
        repeat (2) tick();
        in_lock[0] = 0;
        repeat (2) tick();
        in_clr[0] = 1;
        tick();
        in_clr[0] = 0;
        check("t5_set_wins", 32'(obs[0][8]), 1);
        check("t5_cnt_set", 32'(obs[0][7:0]), 2);
        tick();
        in_clr[0] = 1;
        tick();
        in_clr[0] = 0;
        check("t5_cleared", 32'(obs[0][8]), 0);
        check("t5_cnt_kept", 32'(obs[0][7:0]), 2);
        iter = 0;
        while (n_loss[0] < 260 && iter < 1200) begin
            iter++;
            in_lock[0] = 1;
            repeat ($urandom_range(4, 24)) begin
                in_clr[0] = $urandom_range(0, 7) == 0;
                tick();
            end
            in_lock[0] = 0;
            repeat ($urandom_range(1, 3)) begin
                in_clr[0] = $urandom_range(0, 7) == 0;
                tick();
            end
        end
        in_clr[0] = 0;
        check("t6_sat", 32'(obs[0][7:0]), 255);
        in_lock[0] = 1;
        repeat (20) tick();
        check("t6_in_run", 32'(obs[0][11]), 1);
        in_rst[0] = 1;
        tick();
        check("t6_reset", 32'(obs[0]), 32'h1000);
        in_rst[0] = 0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
